// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the shift-add multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // One add-and-shift step per multiplier bit.
    localparam int MULT_ITERS = 16;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/full_adder_sixteen_bit.sv
// rtl/full_adder_sixteen_bit.sv - 16-bit ripple-carry adder stage
//
// Ports:
//   i_inp0, i_inp1 : 16-bit addends
//   i_cin          : carry in
//   o_sum          : 16-bit sum
//   o_cout         : carry out (17th bit of the result)
module full_adder_sixteen_bit (
    input  logic [15:0] i_inp0,
    input  logic [15:0] i_inp1,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);

    logic [16:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar g = 0; g < 16; g++) begin : g_bit
        assign o_sum[g]     = i_inp0[g] ^ i_inp1[g] ^ w_carry[g];
        assign w_carry[g+1] = (i_inp0[g] & i_inp1[g]) |
                              (w_carry[g] & (i_inp0[g] ^ i_inp1[g]));
    end

    assign o_cout = w_carry[16];

endmodule

// File: rtl/mult_shift_add_sixteen_bit.sv
// rtl/mult_shift_add_sixteen_bit.sv - multi-cycle unsigned 16x16->32 shift-add multiplier
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   start  : request, accepted only in IDLE or DONE
//   mcand  : multiplicand, captured on accepted start
//   mplier : multiplier, captured on accepted start
//   busy   : high while iterating
//   done   : one-cycle pulse, hi/lo hold the final product
//   hi, lo : product[31:16], product[15:0]
module mult_shift_add_sixteen_bit
    import mult_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] hi,
    output logic [15:0] lo
);

    mult_state_t      r_state;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_mcand;
    logic [31:0]      r_product;
    logic             r_busy;
    logic             r_done;

    logic [15:0]      w_addend;
    logic [15:0]      w_sum;
    logic             w_cout;

    // Multiplier bits are consumed from product[0]; the upper half accumulates.
    assign w_addend = r_product[0] ? r_mcand : 16'h0000;

    full_adder_sixteen_bit u_adder (
        .i_inp0 (r_product[31:16]),
        .i_inp1 (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_mcand   <= 16'h0000;
            r_product <= 32'h0000_0000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mcand   <= mcand;
                        r_product <= {16'h0000, mplier};
                        r_count   <= '0;
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end else begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b0;
                    end
                end
                RUN: begin
                    // Carry-out becomes bit 31 so no partial-sum bit is lost on the shift.
                    r_product <= {w_cout, w_sum, r_product[15:1]};
                    r_count   <= r_count + 1'b1;
                    if (r_count == CNT_W'(MULT_ITERS - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_product[31:16];
    assign lo   = r_product[15:0];

endmodule
